// File: rtl/switchreader.sv
// Slide-switch reader: synchronises SW7..SW0, debounces them as one 8-bit
// vector on a prescaled sample tick, and reports the settled value, its bar
// level and a one-clock strobe on every accepted change.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | sampled switches match the accepted value; nothing pending
// SETTLE | a different value (candidate) is being counted over sample ticks
module switchreader #(
  parameter int CLKDIV = 50000,
  parameter int STABLE = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       SW7,
  input  logic       SW6,
  input  logic       SW5,
  input  logic       SW4,
  input  logic       SW3,
  input  logic       SW2,
  input  logic       SW1,
  input  logic       SW0,
  output logic [7:0] data,
  output logic [3:0] level,
  output logic       strobe
);

  // A CLKDIV of 1 still needs a 1-bit prescaler so the compare stays legal.
  localparam int              PW         = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLKDIV - 1);
  localparam logic [3:0]      COUNT_LAST = 4'(STABLE - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  logic [7:0]    sw_raw;
  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [7:0]    cand_q, cand_d;
  logic [3:0]    count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    level_q, level_d;
  logic          strobe_q, strobe_d;
  logic          accept;
  logic [7:0]    accept_val;

  assign sw_raw = {SW7, SW6, SW5, SW4, SW3, SW2, SW1, SW0};

  // Bar level: 0 for an all-off vector, else highest set bit index + 1.
  function automatic logic [3:0] bar_level(input logic [7:0] v);
    logic [3:0] lv;
    lv = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) lv = 4'(i + 1);
    end
    return lv;
  endfunction

  // Two-stage synchroniser for the raw switch inputs.
  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
  end

  // Free-running prescaler; tick marks its last count.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Debounce FSM next-state and output logic, advancing only on tick.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    count_d    = count_q;
    data_d     = data_q;
    level_d    = level_q;
    strobe_d   = 1'b0;
    accept     = 1'b0;
    accept_val = sync2_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (sync2_q != data_q) begin
            if (STABLE == 1) begin
              accept     = 1'b1;
              accept_val = sync2_q;
            end else begin
              cand_d  = sync2_q;
              count_d = 4'd1;
              state_d = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (sync2_q != cand_q) begin
            if (sync2_q == data_q) begin
              state_d = IDLE;
            end else begin
              cand_d  = sync2_q;
              count_d = 4'd1;
            end
          end else if (count_q < COUNT_LAST) begin
            count_d = count_q + 4'd1;
          end else begin
            accept     = 1'b1;
            accept_val = cand_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      data_d   = accept_val;
      level_d  = bar_level(accept_val);
      strobe_d = 1'b1;
      state_d  = IDLE;
    end
  end

  // All registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      presc_q  <= '0;
      state_q  <= IDLE;
      cand_q   <= 8'h00;
      count_q  <= 4'd0;
      data_q   <= 8'h00;
      level_q  <= 4'd0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      presc_q  <= presc_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      data_q   <= data_d;
      level_q  <= level_d;
      strobe_q <= strobe_d;
    end
  end

  assign data   = data_q;
  assign level  = level_q;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_switchreader.sv
// Bench for switchreader: a slow instance (CLKDIV=4, STABLE=3) and a fast
// instance (CLKDIV=1, STABLE=1) are compared every cycle against a
// run-length reference model, plus directed end-of-scenario checks.
module tb_switchreader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw_a = 8'h00;
  logic [7:0] sw_b = 8'h00;
  logic [7:0] data_a, data_b;
  logic [3:0] level_a, level_b;
  logic       strobe_a, strobe_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int nstrobe_a = 0;
  int nstrobe_b = 0;

  // Reference model state, index 0 = slow instance, 1 = fast instance.
  logic [7:0] m_s1[2];
  logic [7:0] m_s2[2];
  logic [7:0] m_data[2];
  logic [3:0] m_level[2];
  logic       m_strobe[2];
  logic [7:0] m_runv[2];
  int         m_runl[2];
  int         m_pc[2];

  always #5 clock = ~clock;

  switchreader #(.CLKDIV(4), .STABLE(3)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .SW7(sw_a[7]), .SW6(sw_a[6]), .SW5(sw_a[5]), .SW4(sw_a[4]),
    .SW3(sw_a[3]), .SW2(sw_a[2]), .SW1(sw_a[1]), .SW0(sw_a[0]),
    .data(data_a), .level(level_a), .strobe(strobe_a)
  );

  switchreader #(.CLKDIV(1), .STABLE(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .SW7(sw_b[7]), .SW6(sw_b[6]), .SW5(sw_b[5]), .SW4(sw_b[4]),
    .SW3(sw_b[3]), .SW2(sw_b[2]), .SW1(sw_b[1]), .SW0(sw_b[0]),
    .data(data_b), .level(level_b), .strobe(strobe_b)
  );

  function automatic int cdiv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int stab(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // Number of significant bits of v, i.e. the bar level.
  function automatic int bar(input int v);
    int n = 0;
    while (v > 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  // A value is accepted once the last STABLE tick samples all equal it and it
  // differs from the current output; the sample is the switch value 2 clocks old.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_s1[i] = 8'h00; m_s2[i] = 8'h00; m_data[i] = 8'h00; m_level[i] = 4'd0;
        m_strobe[i] = 1'b0; m_runv[i] = 8'h00; m_runl[i] = 0; m_pc[i] = 0;
      end else begin
        logic [7:0] smp;
        bit tk;
        smp = m_s2[i];
        tk = (m_pc[i] == cdiv(i) - 1);
        m_strobe[i] = 1'b0;
        if (tk) begin
          if (m_runl[i] > 0 && smp == m_runv[i]) begin
            if (m_runl[i] < 100) m_runl[i]++;
          end else begin
            m_runv[i] = smp;
            m_runl[i] = 1;
          end
          if (smp != m_data[i] && m_runl[i] >= stab(i)) begin
            m_data[i]   = smp;
            m_level[i]  = 4'(bar(int'(smp)));
            m_strobe[i] = 1'b1;
          end
        end
        m_pc[i] = tk ? 0 : m_pc[i] + 1;
        m_s2[i] = m_s1[i];
        m_s1[i] = (i == 0) ? sw_a : sw_b;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; model on the rising edge, compare on the falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check("data_a",   data_a,   m_data[0]);
      check("level_a",  {4'd0, level_a}, {4'd0, m_level[0]});
      check("strobe_a", {7'd0, strobe_a}, {7'd0, m_strobe[0]});
      check("data_b",   data_b,   m_data[1]);
      check("level_b",  {4'd0, level_b}, {4'd0, m_level[1]});
      check("strobe_b", {7'd0, strobe_b}, {7'd0, m_strobe[1]});
      if (strobe_a) nstrobe_a++;
      if (strobe_b) nstrobe_b++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 8'h00; m_s2[i] = 8'h00; m_data[i] = 8'h00; m_level[i] = 4'd0;
      m_strobe[i] = 1'b0; m_runv[i] = 8'h00; m_runl[i] = 0; m_pc[i] = 0;
    end

    // Reset with all switches on, then release.
    reset_n = 1'b0;
    sw_a = 8'hFF;
    step(2);
    check("reset_data",   data_a, 8'h00);
    check("reset_level",  {4'd0, level_a}, 8'd0);
    check("reset_strobe", {7'd0, strobe_a}, 8'd0);
    reset_n = 1'b1;
    nstrobe_a = 0;
    step(14);
    check("release_data",    data_a, 8'hFF);
    check("release_level",   {4'd0, level_a}, 8'd8);
    check("release_strobes", 8'(nstrobe_a), 8'd1);

    // Fast instance follows every change with one strobe each.
    nstrobe_b = 0;
    sw_b = 8'h02; step(1);
    sw_b = 8'h03; step(1);
    sw_b = 8'h80; step(1);
    step(5);
    check("fast_data",    data_b, 8'h80);
    check("fast_level",   {4'd0, level_b}, 8'd8);
    check("fast_strobes", 8'(nstrobe_b), 8'd3);

    // Clean change 00 -> 05 and a long hold with no repeat strobe.
    sw_a = 8'h00; step(20);
    sw_a = 8'h05;
    nstrobe_a = 0;
    step(14);
    check("clean_data",    data_a, 8'h05);
    check("clean_level",   {4'd0, level_a}, 8'd3);
    check("clean_strobes", 8'(nstrobe_a), 8'd1);
    step(40);
    check("hold_strobes",  8'(nstrobe_a), 8'd1);

    // Bounce 00 -> 10 -> 00 -> 10, one tick each, then hold 10.
    sw_a = 8'h00; step(20);
    nstrobe_a = 0;
    sw_a = 8'h10; step(4);
    sw_a = 8'h00; step(4);
    sw_a = 8'h10; step(4);
    check("bounce_hold_data", data_a, 8'h00);
    step(16);
    check("bounce_data",    data_a, 8'h10);
    check("bounce_level",   {4'd0, level_a}, 8'd5);
    check("bounce_strobes", 8'(nstrobe_a), 8'd1);

    // Glitch back to the accepted value: no strobe.
    sw_a = 8'h81; step(20);
    nstrobe_a = 0;
    sw_a = 8'h01; step(4);
    sw_a = 8'h81; step(20);
    check("glitch_data",    data_a, 8'h81);
    check("glitch_level",   {4'd0, level_a}, 8'd8);
    check("glitch_strobes", 8'(nstrobe_a), 8'd0);

    // Reset in the middle of settling, then re-accept the held value.
    sw_a = 8'h00; step(20);
    sw_a = 8'h40; step(10);
    reset_n = 1'b0;
    nstrobe_a = 0;
    step(1);
    check("midreset_data",   data_a, 8'h00);
    check("midreset_level",  {4'd0, level_a}, 8'd0);
    check("midreset_strobe", {7'd0, strobe_a}, 8'd0);
    reset_n = 1'b1;
    step(16);
    check("reaccept_data",    data_a, 8'h40);
    check("reaccept_level",   {4'd0, level_a}, 8'd7);
    check("reaccept_strobes", 8'(nstrobe_a), 8'd1);

    // Randomized switch activity with short glitches and long holds.
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 3) == 0) sw_a = 8'(1 << $urandom_range(0, 7));
      else sw_a = 8'($urandom);
      sw_b = 8'($urandom);
      step($urandom_range(1, 18));
      if ($urandom_range(0, 30) == 0) begin
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
      end
    end
    step(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/switchreader.md
Name: switchreader

Overview:
- Input-side peripheral for the Basys / Spartan-3E boards: reads the eight slide switches SW7..SW0.
- Synchronises and debounces the switches as one 8-bit vector, presents the settled value on `data`, and reports it as a bar level on `level`.
- `level` is the inverse of the LED bar-graph mapping: 0 when no switch is on, otherwise the index of the highest switch that is on, plus 1.
- Emits a one-cycle `strobe` whenever the settled value changes. Downstream logic, including the bar-graph output, consumes `data` and `level`.

Parameters:
- CLKDIV, 50000, sample-tick period in clocks (1 ms at 50 MHz); legal range ≥1.
- STABLE, 4, number of consecutive identical sample ticks needed to accept a new value; legal range 1..15.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- SW7..SW0  input  1 each  raw asynchronous slide-switch inputs, SW0 = bit 0
- data  output  8  debounced switch vector
- level  output  4  bar level of `data`, range 0..8
- strobe  output  1  one-clock pulse when `data` or `level` updates

Behaviour:
- Reset: one clock with reset_n=0 clears every register.
  - Outputs: data=8'h00, level=0, strobe=0.
  - Internal: synchroniser, prescaler, candidate, count, state=IDLE.
  - reset_n is sampled only on clock edges; there is no asynchronous path.
- Synchroniser: two-flop chain per bit. `sample` is the second-stage output, 2 clocks of latency.
- Prescaler:
  - Counts 0..CLKDIV-1 and wraps to 0.
  - `tick` is asserted for the one cycle where the count equals CLKDIV-1.
  - With CLKDIV=1, tick is high every cycle.
- State machine, evaluated only on cycles with tick=1:
  - IDLE, sample==data: stay in IDLE.
  - IDLE, sample!=data: candidate<=sample, count<=1, go to SETTLE. If STABLE==1, accept immediately instead (see acceptance).
  - SETTLE, sample!=candidate: candidate<=sample, count<=1. Stay in SETTLE, unless sample==data, which returns to IDLE with no strobe.
  - SETTLE, sample==candidate, count<STABLE-1: count<=count+1.
  - SETTLE, sample==candidate, count==STABLE-1: accept.
- Acceptance (single edge):
  - data<=candidate (or sample when STABLE==1).
  - level<=f(value), where f = 0 if value==0, else (index of highest set bit)+1.
  - strobe<=1; state<=IDLE.
- strobe: high for exactly one clock after the accept edge, 0 on every other cycle. It never repeats while the value is unchanged.
- Latency: from a clean input change to data update ≤ 2 + STABLE·CLKDIV clocks.
- Non-tick cycles: state, candidate, count and data hold.
- Reset while in SETTLE: state returns to IDLE, data=0, no strobe. After reset, a held nonzero switch value is re-accepted through the normal STABLE path.
- Width rules:
  - count is 4 bits and never exceeds STABLE-1.
  - level is 4 bits; level=8 only when bit 7 is set.

Test Plan (CLKDIV=4, STABLE=3 unless noted):
- Reset: hold reset_n=0 for 2 clocks with SW=8'hFF → data=00, level=0, strobe=0. Release → data=FF, level=8, single strobe at ≤ 2+3·4=14 clocks.
- Clean change: SW 00→05, held → data=05, level=3 after 3 ticks, one strobe pulse. Hold 10 more ticks → no further strobe.
- Bounce: SW toggles 00→10→00→10 on consecutive ticks, then holds 10 → data stays 00 until 3 consecutive ticks of 10, then data=10, level=5, exactly one strobe.
- Glitch back: data=81, SW pulses to 01 for 1 tick then returns to 81 → state back to IDLE, data=81, level=8, no strobe.
- Reset mid-settle: SW 00→40, assert reset_n=0 after the second tick → data=00, level=0, no strobe. Release with SW=40 → accept after 3 ticks, data=40, level=7.
- Fast mode (CLKDIV=1, STABLE=1): SW changes 02→03→80 on successive clocks → data follows each value 2–3 clocks later (two synchroniser stages plus the accept edge), level 2→2→8, one strobe per change.
